// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle game datapath.
package game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam int unsigned DEF_FIELD_LEFT  = 265;
  localparam int unsigned DEF_FIELD_RIGHT = 663;
  localparam int unsigned DEF_GROUND_Y    = 450;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, stepped when advance is high.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= LFSR_SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/obstacle_collider.sv
// Scrolls one ground obstacle, scores clears and latches game-over on contact.
// Define RAND_GAP_EN to add an LFSR-driven random gap to the respawn column.
module obstacle_collider
  import game_pkg::*;
#(
  parameter int unsigned PLAYER_W    = 50,
  parameter int unsigned PLAYER_H    = 50,
  parameter int unsigned OBST_W      = 30,
  parameter int unsigned OBST_H      = 40,
  parameter int unsigned FIELD_LEFT  = DEF_FIELD_LEFT,
  parameter int unsigned FIELD_RIGHT = DEF_FIELD_RIGHT,
  parameter int unsigned GROUND_Y    = DEF_GROUND_Y,
  parameter int unsigned MAX_STEP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [15:0] x_player,
  input  logic [15:0] y_player,
  output logic [15:0] obstacle_x,
  output logic [15:0] obstacle_y,
  output logic [15:0] score,
  output logic        hit,
  output logic        game_over
);

  localparam logic [15:0] OBST_Y = 16'(GROUND_Y - OBST_H);

  state_t      state_q, state_d;
  logic [15:0] ox_q, ox_d;
  logic [15:0] score_q, score_d;
  logic        hit_q, hit_d;
  logic [15:0] respawn_x;
  logic [15:0] speed;
  logic [15:0] step;
  logic        overlap;

`ifdef RAND_GAP_EN
  logic [15:0] lfsr_value;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (tick),
    .value   (lfsr_value)
  );

  assign respawn_x = 16'(FIELD_RIGHT) + {9'd0, lfsr_value[5:0], 1'b0};
`else
  assign respawn_x = 16'(FIELD_RIGHT);
`endif

  assign speed = score_q >> 3;
  assign step  = (speed > 16'(MAX_STEP - 1)) ? 16'(MAX_STEP) : speed + 16'd1;

  // 17-bit sums keep the box edges from wrapping near 16'hFFFF.
  assign overlap = ({1'b0, x_player} < {1'b0, ox_q} + 17'(OBST_W))       &&
                   ({1'b0, ox_q}     < {1'b0, x_player} + 17'(PLAYER_W)) &&
                   ({1'b0, y_player} < {1'b0, OBST_Y} + 17'(OBST_H))     &&
                   ({1'b0, OBST_Y}   < {1'b0, y_player} + 17'(PLAYER_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ox_q    <= 16'(FIELD_RIGHT);
      score_q <= 16'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      score_q <= score_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    score_d = score_q;
    hit_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        // Contact takes priority over a same-cycle tick.
        if (overlap) begin
          state_d = OVER;
          hit_d   = 1'b1;
        end else if (tick) begin
          if ({1'b0, ox_q} < 17'(FIELD_LEFT) + {1'b0, step}) begin
            ox_d = respawn_x;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end else begin
            ox_d = ox_q - step;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d = RUN;
          score_d = 16'd0;
          ox_d    = respawn_x;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obstacle_x = ox_q;
    obstacle_y = OBST_Y;
    score      = score_q;
    hit        = hit_q;
    game_over  = (state_q == OVER);
  end

endmodule

// File: tb/tb_obstacle_collider.sv
// Directed bench for obstacle_collider; inputs driven and outputs sampled on negedge.
module tb_obstacle_collider;

  logic        clk = 1'b0;
  logic        reset, tick, start;
  logic [15:0] x_player, y_player;
  logic [15:0] obstacle_x, obstacle_y, score;
  logic        hit, game_over;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_lfsr;
  logic [15:0] gap_src;
  logic [15:0] col;
  int          n;
  bit          done;

  always #5 clk = ~clk;

  obstacle_collider dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .x_player   (x_player),
    .y_player   (y_player),
    .obstacle_x (obstacle_x),
    .obstacle_y (obstacle_y),
    .score      (score),
    .hit        (hit),
    .game_over  (game_over)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] respawn_col(input logic [15:0] src);
`ifdef RAND_GAP_EN
    return 16'd663 + {9'd0, src[5:0], 1'b0};
`else
    return 16'd663 + (src & 16'h0000);
`endif
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    gap_src = m_lfsr;
    m_lfsr  = lfsr_next(m_lfsr);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    x_player = 16'd300; y_player = 16'd300;
    m_lfsr = 16'hACE1; gap_src = 16'hACE1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state and idle ticks
    check16("rst_ox", obstacle_x, 16'd663);
    check16("rst_oy", obstacle_y, 16'd410);
    check16("rst_score", score, 16'd0);
    check16("rst_go", {15'd0, game_over}, 16'd0);
    check16("rst_hit", {15'd0, hit}, 16'd0);
    for (int i = 0; i < 3; i++) do_tick();
    check16("idle_ox", obstacle_x, 16'd663);

    // Clear jump: player above the obstacle
    do_start();
    check16("start_go", {15'd0, game_over}, 16'd0);
    for (int i = 0; i < 398; i++) do_tick();
    check16("clear_ox265", obstacle_x, 16'd265);
    check16("clear_score0", score, 16'd0);
    do_tick();
    col = respawn_col(gap_src);
    check16("clear_respawn", obstacle_x, col);
    check16("clear_score1", score, 16'd1);
    check16("clear_hit", {15'd0, hit}, 16'd0);
    check16("clear_go", {15'd0, game_over}, 16'd0);

    // Speed ramp through score 24
    for (int s = 1; s < 24; s++) begin
      n = 0; done = 1'b0;
      while (!done && n < 1000) begin
        do_tick();
        n++;
        if (score != 16'(s)) done = 1'b1;
        else if (s == 8 && n <= 2) check16("ramp_step2", obstacle_x, col - 16'(2 * n));
      end
      col = respawn_col(gap_src);
      check16("ramp_score", score, 16'(s + 1));
      check16("ramp_respawn", obstacle_x, col);
`ifndef RAND_GAP_EN
      check16("ramp_ticks", 16'(n), (s < 8) ? 16'd399 : (s < 16) ? 16'd200 : 16'd133);
`endif
    end
    do_tick();
    check16("step4_a", obstacle_x, col - 16'd4);
    do_tick();
    check16("step4_b", obstacle_x, col - 16'd8);

    // Simultaneous tick and first overlap
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m_lfsr = 16'hACE1;
    y_player = 16'd300;
    do_start();
    for (int i = 0; i < 314; i++) do_tick();
    check16("sim_ox349", obstacle_x, 16'd349);
    @(negedge clk) begin y_player = 16'd400; tick = 1'b1; end
    @(negedge clk) tick = 1'b0;
    m_lfsr = lfsr_next(m_lfsr);
    check16("sim_ox", obstacle_x, 16'd349);
    check16("sim_score", score, 16'd0);
    check16("sim_hit", {15'd0, hit}, 16'd1);
    check16("sim_go", {15'd0, game_over}, 16'd1);
    @(negedge clk);
    check16("sim_hit_drop", {15'd0, hit}, 16'd0);
    check16("sim_go_hold", {15'd0, game_over}, 16'd1);

    // Restart from OVER, then ground collision
    gap_src = m_lfsr;
    do_start();
    col = respawn_col(gap_src);
    check16("restart_score", score, 16'd0);
    check16("restart_go", {15'd0, game_over}, 16'd0);
    check16("restart_ox", obstacle_x, col);
    for (int i = 0; i < int'(col) - 349; i++) do_tick();
    check16("gnd_ox349", obstacle_x, 16'd349);
    check16("gnd_hit_early", {15'd0, hit}, 16'd0);
    @(negedge clk);
    check16("gnd_hit", {15'd0, hit}, 16'd1);
    check16("gnd_go", {15'd0, game_over}, 16'd1);
    @(negedge clk);
    check16("gnd_hit_drop", {15'd0, hit}, 16'd0);
    for (int i = 0; i < 3; i++) do_tick();
    check16("gnd_frozen_ox", obstacle_x, 16'd349);
    check16("gnd_frozen_score", score, 16'd0);
    check16("gnd_go_hold", {15'd0, game_over}, 16'd1);

    // Reset mid-run overrides a concurrent tick
    y_player = 16'd300;
    gap_src = m_lfsr;
    do_start();
    col = respawn_col(gap_src);
    for (int i = 0; i < 5; i++) do_tick();
    check16("run_ox", obstacle_x, col - 16'd5);
    @(negedge clk) begin reset = 1'b1; tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; tick = 1'b0; end
    m_lfsr = 16'hACE1;
    check16("mid_rst_ox", obstacle_x, 16'd663);
    check16("mid_rst_score", score, 16'd0);
    check16("mid_rst_go", {15'd0, game_over}, 16'd0);
    check16("mid_rst_hit", {15'd0, hit}, 16'd0);
    do_tick();
    check16("mid_rst_idle", obstacle_x, 16'd663);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obstacle_collider.md
# obstacle_collider

Downstream consumer of the player position. It scrolls a single ground obstacle leftward across the playfield on each 1 ms tick and checks the obstacle box against the player box every clock. It keeps a score of cleared obstacles and latches game-over on contact. Its outputs feed the VGA renderer (obstacle box) and the HUD (score, game_over).

## Interface
Parameters:
- PLAYER_W, 50, player box width in pixels
- PLAYER_H, 50, player box height in pixels
- OBST_W, 30, obstacle width
- OBST_H, 40, obstacle height
- FIELD_LEFT, 265, leftmost playfield column
- FIELD_RIGHT, 663, spawn column
- GROUND_Y, 450, ground line (obstacle bottom edge)
- MAX_STEP, 4, maximum pixels moved per tick

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- tick  in  1  single-cycle 1 ms strobe, synchronous to clk
- start  in  1  level; begins or restarts a run
- x_player, y_player  in  16  top-left corner of the player box
- obstacle_x, obstacle_y  out  16  top-left corner of the obstacle box
- score  out  16  count of obstacles cleared
- hit  out  1  one-cycle pulse on contact
- game_over  out  1  high while in OVER

## Operation
- States are IDLE, RUN and OVER.
- **IDLE:** obstacle parked at FIELD_RIGHT. Ticks are ignored. start=1 → RUN.
- **RUN, tick=1:**
  - step = 1 + min(score>>3, MAX_STEP-1).
  - If obstacle_x < FIELD_LEFT + step: respawn and increment score. score saturates at 16'hFFFF.
  - Otherwise obstacle_x -= step.
- **RUN, every clk:** overlap = (x_player < ox+OBST_W) && (ox < x_player+PLAYER_W) && (y_player < oy+OBST_H) && (oy < y_player+PLAYER_H).
  - All comparisons are strict and unsigned, on 17-bit sums so there is no wrap.
  - overlap=1 → OVER, with hit pulsed.
- **Collision and tick in the same cycle:** collision wins. The obstacle does not move and score does not change.
- **Collision and respawn:** impossible in the same cycle, because the collision is evaluated first.
- **OVER:** obstacle and score are frozen. start=1 → RUN with score=0 and obstacle_x at the respawn position.
- start is ignored while in RUN.
- obstacle_y is constant at GROUND_Y - OBST_H (410 with defaults).

## Timing
- Reset values: state IDLE, obstacle_x=FIELD_RIGHT, obstacle_y=GROUND_Y-OBST_H, score=0, hit=0, game_over=0.
- reset mid-run overrides everything within one cycle.
- Movement: a tick in cycle N makes the new obstacle_x visible in cycle N+1.
- Collision: the compare is combinational on the registered obstacle and the current player inputs. hit and game_over are registered and assert in cycle N+1 after the overlapping cycle N.
- hit is high for exactly one cycle. game_over holds until start or reset.
- Start from IDLE/OVER: start sampled in cycle N → RUN in N+1. The first movement happens on the next tick.

## Configuration
- **RAND_GAP_EN defined:** the respawn column is FIELD_RIGHT + {lfsr[5:0],1'b0}, which gives 0..126 extra pixels of random gap.
  - The LFSR is 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, with seed 16'hACE1 on reset.
  - It advances on every tick, in all states.
- **RAND_GAP_EN undefined:** respawn is always at FIELD_RIGHT and no LFSR is instantiated.

## Structure
- Package game_pkg holds:
  - the state_t enum (IDLE, RUN, OVER);
  - the geometry defaults (FIELD_LEFT, FIELD_RIGHT, GROUND_Y);
  - the LFSR seed and tap constants.
- Sub-module lfsr16 (clk, reset, advance, value[15:0]) is instantiated only under RAND_GAP_EN.

## Test plan
All scenarios use default parameters with RAND_GAP_EN undefined unless stated.
- **Reset:** release reset → obstacle_x=663, obstacle_y=410, score=0, game_over=0, state IDLE. Ticks while idle leave obstacle_x=663.
- **Ground collision:** player (300,400), start, then ticks → obstacle_x=349 after tick 314 → hit pulses one cycle later, game_over=1, obstacle_x stays 349 on further ticks.
- **Clear jump:** player (300,300) constant → after tick 398 obstacle_x=265; tick 399 respawns to 663 with score=1 and no hit.
- **Speed ramp:** force 8 clears → step becomes 2, so obstacle_x decreases 663→661→659. Force score to 24 or more → step=4, capped at MAX_STEP.
- **Simultaneous events:** tick in the same cycle as the first overlap → obstacle_x unchanged, score unchanged, hit=1.
- **Restart and RAND_GAP_EN:**
  - From OVER, assert start → score=0, state RUN.
  - With RAND_GAP_EN and seed ACE1, respawn columns match the golden LFSR sequence from the bench model.
  - Assert reset mid-run → all reset values on the next cycle.
